calc_controller: RTL and testbench
==================================

# calc_controller

Top-level sequencer for the calculator datapath. It accepts decoded keypad events (digits, operator, equals, clear), builds operands A and B in decimal, issues one operation at a time to the `arithmetic` unit, and waits for its `done` with a timeout. It then latches the result for display and allows chaining of the result into the next operation. It sits between the keypad decoder and the `arithmetic` instance, and is the only driver of that unit's `a`, `b`, `state` and `opcode` inputs.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum number of cycles spent in EXECB waiting for `done`.

Ports:
- `CLK`  in  1: system clock; all state updates on the rising edge.
- `RST`  in  1: reset, asynchronous and active-high.
- `clr`  in  1: single-cycle clear request.
- `digit_valid`  in  1: single-cycle strobe qualifying `digit`.
- `digit`  in  4: decimal digit, 0–9.
- `op_valid`  in  1: single-cycle strobe qualifying `op_code`.
- `op_code`  in  4: one of `SUM SUB MUL DIV SQRT POW` from `define.v`.
- `eq_valid`  in  1: single-cycle equals strobe.
- `arith_a`, `arith_b`  out  `INPUTWIDTH`: operands to the arithmetic unit.
- `arith_state`  out  3: controller state code, wired to the arithmetic unit's `state` input.
- `arith_opcode`  out  4: latched opcode.
- `arith_result`  in  `OUTPUTWIDTH`: result from the arithmetic unit.
- `arith_done`  in  1: completion flag from the arithmetic unit.
- `disp`  out  `OUTPUTWIDTH`: value to display.
- `busy`  out  1: high while in EXECB.
- `err`  out  1: high while in ERR.
- `err_code`  out  2: 0 none, 1 divide-by-zero, 2 timeout, 3 invalid op.
- `dig_rej`  out  1: one-cycle pulse when a digit is rejected.

## Operation
- States (3-bit, defined in `define.v`): IDLE=0, ENTA=1, OPSEL=2, ENTB=3, EXECB=4, SHOW=5, ERR=6.
- Event priority within a cycle: `clr` > `eq_valid` > `op_valid` > `digit_valid`. Only the highest-priority event is acted on; lower ones in the same cycle are dropped.
- `clr` in any state: go to IDLE, clear A, B, result and `err_code`.
- IDLE: on a digit, set A=digit and go to ENTA.
- ENTA: on a digit, A = A*10 + digit.
  - On `op_valid` with a valid opcode: latch the opcode. SQRT goes straight to EXECB; any other opcode sets B=0 and goes to OPSEL.
  - On `op_valid` with an invalid opcode: go to ERR with code 3.
- OPSEL: a digit sets B=digit and goes to ENTB. A valid `op_valid` replaces the opcode.
- ENTB: on a digit, B = B*10 + digit. On `eq_valid`:
  - If the opcode is DIV and B=0: go to ERR with code 1. No EXECB is issued.
  - Otherwise go to EXECB.
- EXECB: hold `arith_a`, `arith_b` and `arith_opcode` stable.
  - If `arith_done`=1 at an edge: latch `arith_result` into the result register and go to SHOW.
  - If the cycle count reaches TIMEOUT first: go to ERR with code 2.
- SHOW:
  - `op_valid`: A = result[`INPUTWIDTH`-1:0] (chaining), then follow the same opcode rules as in ENTA.
  - Digit: start a new entry with A=digit and go to ENTA.
  - `eq_valid`: ignored.
- ERR: only `clr` leaves this state.
- Digit accumulation is done at width `INPUTWIDTH`+4. A digit is rejected if it is greater than 9, or if the new value would exceed 2^`INPUTWIDTH`−1. On rejection the operand is unchanged and `dig_rej` pulses. Rejection never causes an error state.
- `disp` by state:
  - IDLE and OPSEL: A.
  - ENTA: A.
  - ENTB: B.
  - EXECB and SHOW: the result register (shows the previous result during EXECB).
  - ERR: 0.
  - A and B are zero-extended to `OUTPUTWIDTH`.
- Events arriving during EXECB, other than `clr`, are dropped.

## Timing
- Reset values: all registers are 0 and the state is IDLE.
  - Therefore `arith_a`=`arith_b`=0, `arith_state`=0, `arith_opcode`=0, `disp`=0, `busy`=0, `err`=0, `err_code`=0, `dig_rej`=0.
- All outputs are registered or decoded directly from registered state. There is no combinational path from input to output.
- `eq_valid` sampled at edge k: `arith_state`=EXECB and `busy`=1 from edge k.
- `arith_done` sampled at edge m: SHOW and `disp`=result from edge m, `busy`=0.
- Timeout: the counter resets on EXECB entry. ERR is entered on the edge at which the count equals TIMEOUT, i.e. TIMEOUT cycles after entry.
- `RST` mid-EXECB: immediate return to IDLE with outputs at reset values. A late `done` from the arithmetic unit is ignored because the state is no longer EXECB.
- `dig_rej` is high for exactly one cycle after the rejecting edge.

## Structure
- `define.v` holds:
  - the state codes above;
  - the existing opcode codes;
  - `INPUTWIDTH` and `OUTPUTWIDTH`;
  - the error codes ERR_NONE, ERR_DIV0, ERR_TMO, ERR_OP.
- Sub-module `operand_acc`: decimal accumulator handling load, append, clear and rejection, with output `dig_rej`. It is instantiated once and shared by A and B through a select input.
- The FSM, timeout counter and result register live in `calc_controller`.

## Test plan
- Digits 1,5, SUM, 1,0, `=`, with a stub that raises `done` 3 cycles later → `busy` high for 3 cycles, then SHOW, `disp`=25, `err`=0.
- 1,0,0, DIV, 0, `=` → ERR, `err_code`=1, `arith_state` never equals EXECB, `disp`=0. Then `clr` → IDLE with all outputs 0.
- 1,6, SQRT → EXECB with no B entry. With the stub returning 4 → SHOW, `disp`=4.
- 2, POW, 3, `=`, stub result 8, then MUL, 7, `=` → A=8 (chained), final `disp`=56.
- Stub never asserts `done` → ERR with `err_code`=2 exactly TIMEOUT cycles after EXECB entry. Same run with `RST` asserted mid-EXECB → immediate IDLE, outputs 0.
- Enter 4294967295 then one more digit → `dig_rej` pulses for one cycle and A is unchanged. Digit 12 is also rejected. `clr` together with `eq_valid` in the same cycle → IDLE.

Source files
------------

// File: rtl/calc_controller_pkg.sv
// Shared constants for the calculator sequencer: widths, state codes,
// arithmetic opcodes and error codes.
package calc_controller_pkg;

  localparam int INPUTWIDTH  = 32;
  localparam int OUTPUTWIDTH = 64;
  // Digits are accumulated with headroom so overflow past INPUTWIDTH is visible
  localparam int ACCWIDTH    = INPUTWIDTH + 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ENTA  = 3'd1;
  localparam logic [2:0] ST_OPSEL = 3'd2;
  localparam logic [2:0] ST_ENTB  = 3'd3;
  localparam logic [2:0] ST_EXECB = 3'd4;
  localparam logic [2:0] ST_SHOW  = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

  localparam logic [3:0] OP_SUM  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SQRT = 4'd4;
  localparam logic [3:0] OP_POW  = 4'd5;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_DIV0 = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_OP   = 2'd3;

  function automatic logic op_is_valid(input logic [3:0] op);
    return op <= OP_POW;
  endfunction

endpackage

// File: rtl/calc_controller_operand_acc.sv
// Decimal accumulator shared by operands A and B; loads, appends or clears a
// digit and rejects digits above 9 or results that do not fit INPUTWIDTH.
module operand_acc
  import calc_controller_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_clr,
  input  logic                  i_dig_en,
  input  logic                  i_append,
  input  logic                  i_sel_b,
  input  logic [3:0]            i_digit,
  input  logic                  i_zero_b,
  input  logic                  i_load_a,
  input  logic [INPUTWIDTH-1:0] i_load_a_val,
  output logic                  o_accept,
  output logic [INPUTWIDTH-1:0] o_a,
  output logic [INPUTWIDTH-1:0] o_b,
  output logic                  o_dig_rej
);

  logic [INPUTWIDTH-1:0] r_a;
  logic [INPUTWIDTH-1:0] r_b;
  logic                  r_dig_rej;
  logic [INPUTWIDTH-1:0] w_cur;
  logic [ACCWIDTH-1:0]   w_next;

  assign w_cur    = i_sel_b ? r_b : r_a;
  assign w_next   = i_append ? (ACCWIDTH'(w_cur) * ACCWIDTH'(10) + ACCWIDTH'(i_digit))
                             : ACCWIDTH'(i_digit);
  assign o_accept = (i_digit <= 4'd9) && (w_next[ACCWIDTH-1:INPUTWIDTH] == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a       <= '0;
      r_b       <= '0;
      r_dig_rej <= 1'b0;
    end else begin
      r_dig_rej <= i_dig_en && !o_accept;
      if (i_clr) begin
        r_a <= '0;
        r_b <= '0;
      end else begin
        if (i_load_a) r_a <= i_load_a_val;
        if (i_zero_b) r_b <= '0;
        if (i_dig_en && o_accept) begin
          if (i_sel_b) r_b <= w_next[INPUTWIDTH-1:0];
          else         r_a <= w_next[INPUTWIDTH-1:0];
        end
      end
    end
  end

  assign o_a       = r_a;
  assign o_b       = r_b;
  assign o_dig_rej = r_dig_rej;

endmodule

// File: rtl/calc_controller.sv
// Calculator sequencer: turns keypad events into operands/opcode for the
// arithmetic unit, waits for done with a timeout, latches and chains results.
//   state | meaning
//   IDLE  | cleared, waiting for first digit of A
//   ENTA  | accumulating A
//   OPSEL | opcode latched, waiting for first digit of B
//   ENTB  | accumulating B
//   EXECB | operation issued, waiting for done or timeout
//   SHOW  | result displayed, may be chained
//   ERR   | error latched, only clr leaves
module calc_controller
  import calc_controller_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   clr,
  input  logic                   digit_valid,
  input  logic [3:0]             digit,
  input  logic                   op_valid,
  input  logic [3:0]             op_code,
  input  logic                   eq_valid,
  output logic [INPUTWIDTH-1:0]  arith_a,
  output logic [INPUTWIDTH-1:0]  arith_b,
  output logic [2:0]             arith_state,
  output logic [3:0]             arith_opcode,
  input  logic [OUTPUTWIDTH-1:0] arith_result,
  input  logic                   arith_done,
  output logic [OUTPUTWIDTH-1:0] disp,
  output logic                   busy,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic                   dig_rej
);

  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TMO_LOAD = TW'(TIMEOUT - 1);

  logic [2:0]             r_state;
  logic [3:0]             r_opcode;
  logic [OUTPUTWIDTH-1:0] r_result;
  logic [1:0]             r_err_code;
  logic [TW-1:0]          r_tmo;

  logic w_clr, w_eq, w_op, w_dig, w_op_ok;
  logic w_acc_dig, w_acc_app, w_acc_sel_b, w_zero_b, w_load_a, w_acc_ok;
  logic [INPUTWIDTH-1:0] w_a, w_b;

  // Only the highest-priority event of a cycle is acted on
  assign w_clr   = clr;
  assign w_eq    = eq_valid && !clr;
  assign w_op    = op_valid && !clr && !eq_valid;
  assign w_dig   = digit_valid && !clr && !eq_valid && !op_valid;
  assign w_op_ok = op_is_valid(op_code);

  always_comb begin
    w_acc_dig   = 1'b0;
    w_acc_app   = 1'b0;
    w_acc_sel_b = 1'b0;
    w_zero_b    = 1'b0;
    w_load_a    = 1'b0;
    if (w_dig) begin
      case (r_state)
        ST_IDLE, ST_SHOW: w_acc_dig = 1'b1;
        ST_ENTA: begin
          w_acc_dig = 1'b1;
          w_acc_app = 1'b1;
        end
        ST_OPSEL: begin
          w_acc_dig   = 1'b1;
          w_acc_sel_b = 1'b1;
        end
        ST_ENTB: begin
          w_acc_dig   = 1'b1;
          w_acc_app   = 1'b1;
          w_acc_sel_b = 1'b1;
        end
        default: w_acc_dig = 1'b0;
      endcase
    end
    if (w_op && r_state == ST_SHOW) w_load_a = 1'b1;
    if (w_op && w_op_ok && op_code != OP_SQRT &&
        (r_state == ST_ENTA || r_state == ST_SHOW)) w_zero_b = 1'b1;
  end

  operand_acc u_acc (
    .CLK          (CLK),
    .RST          (RST),
    .i_clr        (w_clr),
    .i_dig_en     (w_acc_dig),
    .i_append     (w_acc_app),
    .i_sel_b      (w_acc_sel_b),
    .i_digit      (digit),
    .i_zero_b     (w_zero_b),
    .i_load_a     (w_load_a),
    .i_load_a_val (r_result[INPUTWIDTH-1:0]),
    .o_accept     (w_acc_ok),
    .o_a          (w_a),
    .o_b          (w_b),
    .o_dig_rej    (dig_rej)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_opcode   <= '0;
      r_result   <= '0;
      r_err_code <= ERR_NONE;
      r_tmo      <= '0;
    end else if (w_clr) begin
      r_state    <= ST_IDLE;
      r_opcode   <= '0;
      r_result   <= '0;
      r_err_code <= ERR_NONE;
      r_tmo      <= TMO_LOAD;
    end else begin
      // Counter is preloaded in every state so EXECB entry always starts fresh
      if (r_state != ST_EXECB) r_tmo <= TMO_LOAD;
      case (r_state)
        ST_IDLE: if (w_dig && w_acc_ok) r_state <= ST_ENTA;
        ST_ENTA, ST_SHOW: begin
          if (w_op) begin
            if (w_op_ok) begin
              r_opcode <= op_code;
              r_state  <= (op_code == OP_SQRT) ? ST_EXECB : ST_OPSEL;
            end else begin
              r_state    <= ST_ERR;
              r_err_code <= ERR_OP;
            end
          end else if (w_dig && w_acc_ok) begin
            r_state <= ST_ENTA;
          end
        end
        ST_OPSEL: begin
          if (w_op && w_op_ok)        r_opcode <= op_code;
          else if (w_dig && w_acc_ok) r_state  <= ST_ENTB;
        end
        ST_ENTB: begin
          if (w_eq) begin
            if (r_opcode == OP_DIV && w_b == '0) begin
              r_state    <= ST_ERR;
              r_err_code <= ERR_DIV0;
            end else begin
              r_state <= ST_EXECB;
            end
          end
        end
        ST_EXECB: begin
          if (arith_done) begin
            r_result <= arith_result;
            r_state  <= ST_SHOW;
          end else if (r_tmo == '0) begin
            r_state    <= ST_ERR;
            r_err_code <= ERR_TMO;
          end else begin
            r_tmo <= r_tmo - TW'(1);
          end
        end
        ST_ERR:  r_state <= ST_ERR;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    disp = '0;
    case (r_state)
      ST_IDLE, ST_ENTA, ST_OPSEL: disp = OUTPUTWIDTH'(w_a);
      ST_ENTB:                    disp = OUTPUTWIDTH'(w_b);
      ST_EXECB, ST_SHOW:          disp = r_result;
      default:                    disp = '0;
    endcase
  end

  assign arith_a      = w_a;
  assign arith_b      = w_b;
  assign arith_state  = r_state;
  assign arith_opcode = r_opcode;
  assign busy         = (r_state == ST_EXECB);
  assign err          = (r_state == ST_ERR);
  assign err_code     = r_err_code;

endmodule

// File: tb/tb_calc_controller.sv
// Self-checking bench for calc_controller: directed scenarios plus random
// calculations against a plain-arithmetic reference and an arithmetic-unit stub.
module tb_calc_controller;
  import calc_controller_pkg::*;

  localparam int TIMEOUT = 64;

  logic                   CLK = 1'b0;
  logic                   RST = 1'b1;
  logic                   clr = 1'b0;
  logic                   digit_valid = 1'b0;
  logic [3:0]             digit = '0;
  logic                   op_valid = 1'b0;
  logic [3:0]             op_code = '0;
  logic                   eq_valid = 1'b0;
  logic [INPUTWIDTH-1:0]  arith_a, arith_b;
  logic [2:0]             arith_state;
  logic [3:0]             arith_opcode;
  logic [OUTPUTWIDTH-1:0] arith_result = '0;
  logic                   arith_done = 1'b0;
  logic [OUTPUTWIDTH-1:0] disp;
  logic                   busy, err, dig_rej;
  logic [1:0]             err_code;

  int n_checks = 0;
  int n_fail   = 0;
  int stub_lat = 3;
  bit stub_hang = 1'b0;
  bit stub_force_done = 1'b0;
  int exec_cycles = 0;

  always #5 CLK = ~CLK;

  calc_controller #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .clr(clr), .digit_valid(digit_valid), .digit(digit),
    .op_valid(op_valid), .op_code(op_code), .eq_valid(eq_valid),
    .arith_a(arith_a), .arith_b(arith_b), .arith_state(arith_state),
    .arith_opcode(arith_opcode), .arith_result(arith_result), .arith_done(arith_done),
    .disp(disp), .busy(busy), .err(err), .err_code(err_code), .dig_rej(dig_rej)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_arith(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] r, t;
    r = '0;
    case (op)
      OP_SUM:  r = 64'(a) + 64'(b);
      OP_SUB:  r = 64'(a) - 64'(b);
      OP_MUL:  r = 64'(a) * 64'(b);
      OP_DIV:  r = (b == 0) ? 64'd0 : 64'(a / b);
      OP_SQRT: for (int i = 15; i >= 0; i--) begin
                 t = r | (64'd1 << i);
                 if (t * t <= 64'(a)) r = t;
               end
      OP_POW:  begin
                 r = 64'd1;
                 for (int i = 0; i < 64 && 32'(i) < b; i++) r = r * 64'(a);
               end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Arithmetic-unit stub: raises done stub_lat cycles after EXECB entry
  initial begin : stub
    int cnt;
    cnt = 0;
    forever begin
      @(negedge CLK);
      if (arith_state == ST_EXECB) begin
        exec_cycles++;
        cnt++;
        if (!stub_hang && cnt == stub_lat) begin
          arith_result = ref_arith(arith_opcode, arith_a, arith_b);
          arith_done   = 1'b1;
        end else begin
          arith_done = 1'b0;
        end
      end else begin
        cnt        = 0;
        arith_done = stub_force_done;
      end
    end
  end

  task automatic press(input bit c, input bit e, input bit o, input logic [3:0] oc,
                       input bit dv, input logic [3:0] d);
    @(negedge CLK);
    clr = c; eq_valid = e; op_valid = o; op_code = oc; digit_valid = dv; digit = d;
    @(negedge CLK);
    clr = 1'b0; eq_valid = 1'b0; op_valid = 1'b0; digit_valid = 1'b0;
  endtask

  task automatic press_digit(input logic [3:0] d); press(0, 0, 0, 4'd0, 1, d); endtask
  task automatic press_op(input logic [3:0] oc);   press(0, 0, 1, oc, 0, 4'd0); endtask
  task automatic press_eq();                       press(0, 1, 0, 4'd0, 0, 4'd0); endtask
  task automatic press_clr();                      press(1, 0, 0, 4'd0, 0, 4'd0); endtask

  task automatic enter_number(input logic [31:0] v, input bit rej_ok);
    int dq[$];
    logic [63:0] t, run;
    t = 64'(v);
    run = '0;
    do begin
      dq.push_front(int'(t % 10));
      t = t / 10;
    end while (t != 0);
    foreach (dq[i]) begin
      if (rej_ok && i > 0 && $urandom_range(0, 3) == 0) begin
        press_digit(4'($urandom_range(10, 15)));
        check_val("rej_pulse", 64'(dig_rej), 64'd1);
        check_val("rej_hold", disp, run);
      end
      press_digit(4'(dq[i]));
      run = run * 10 + 64'(dq[i]);
      check_val("entry_disp", disp, run);
    end
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < TIMEOUT + 8) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_state"}, 64'(arith_state), 64'd0);
    check_val({tag, "_ops"}, {arith_a, arith_b}, 64'd0);
    check_val({tag, "_opcode"}, 64'(arith_opcode), 64'd0);
    check_val({tag, "_disp"}, disp, 64'd0);
    check_val({tag, "_flags"}, 64'({busy, err, err_code, dig_rej}), 64'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n, ex0;
    logic [31:0] a, b;
    logic [63:0] exp_res, last_res;
    logic [3:0] op;
    bit have_res;
    logic [3:0] ops [6];
    ops = '{OP_SUM, OP_SUB, OP_MUL, OP_DIV, OP_SQRT, OP_POW};

    repeat (2) @(negedge CLK);
    check_zero("reset");
    RST = 1'b0;

    // 15 + 10 with done three cycles after issue
    stub_lat = 3;
    press_digit(1); press_digit(5);
    check_val("t1_a", disp, 64'd15);
    press_op(OP_SUM);
    check_val("t1_opsel", 64'(arith_state), 64'(ST_OPSEL));
    press_digit(1); press_digit(0);
    check_val("t1_b", disp, 64'd10);
    press_eq();
    check_val("t1_exec", 64'(arith_state), 64'(ST_EXECB));
    check_val("t1_opnds", {arith_a, arith_b}, {32'd15, 32'd10});
    wait_busy(n);
    check_val("t1_busy_cycles", 64'(n), 64'd3);
    check_val("t1_show", 64'(arith_state), 64'(ST_SHOW));
    check_val("t1_disp", disp, 64'd25);
    check_val("t1_err", 64'(err), 64'd0);

    // divide by zero never issues
    press_clr();
    ex0 = exec_cycles;
    press_digit(1); press_digit(0); press_digit(0);
    press_op(OP_DIV); press_digit(0); press_eq();
    check_val("t2_state", 64'(arith_state), 64'(ST_ERR));
    check_val("t2_errflags", 64'({err, err_code}), 64'({1'b1, ERR_DIV0}));
    check_val("t2_disp", disp, 64'd0);
    press_digit(5); press_eq();
    check_val("t2_sticky", 64'(arith_state), 64'(ST_ERR));
    check_val("t2_no_exec", 64'(exec_cycles), 64'(ex0));
    press_clr();
    check_zero("t2_clr");

    // invalid opcode and op-over-digit priority
    press_digit(3);
    press(0, 0, 1, OP_SUM, 1, 4'd7);
    check_val("prio_state", 64'(arith_state), 64'(ST_OPSEL));
    check_val("prio_disp", disp, 64'd3);
    press_clr();
    press_digit(2); press_op(4'd9);
    check_val("badop", 64'({arith_state, err_code}), 64'({ST_ERR, ERR_OP}));
    press_clr();

    // square root skips B
    stub_lat = 2;
    press_digit(1); press_digit(6); press_op(OP_SQRT);
    check_val("t3_exec", 64'(arith_state), 64'(ST_EXECB));
    check_val("t3_a", 64'(arith_a), 64'd16);
    wait_busy(n);
    check_val("t3_cycles", 64'(n), 64'd2);
    check_val("t3_disp", disp, 64'd4);

    // 2^3 chained into *7
    press_clr();
    stub_lat = 3;
    press_digit(2); press_op(OP_POW); press_digit(3); press_eq();
    wait_busy(n);
    check_val("t4_pow", disp, 64'd8);
    press_op(OP_MUL);
    check_val("t4_chain_a", 64'(arith_a), 64'd8);
    check_val("t4_chain_disp", disp, 64'd8);
    press_digit(7); press_eq();
    wait_busy(n);
    check_val("t4_final", disp, 64'd56);

    // timeout, then reset in the middle of EXECB
    press_clr();
    stub_hang = 1'b1;
    press_digit(1); press_op(OP_SUM); press_digit(2); press_eq();
    wait_busy(n);
    check_val("t5_tmo_cycles", 64'(n), 64'(TIMEOUT));
    check_val("t5_tmo", 64'({err, err_code}), 64'({1'b1, ERR_TMO}));
    check_val("t5_disp", disp, 64'd0);
    press_clr();
    press_digit(1); press_op(OP_SUM); press_digit(2); press_eq();
    repeat (5) @(negedge CLK);
    check_val("t5_busy_pre", 64'(busy), 64'd1);
    #2 RST = 1'b1;
    #1 check_zero("t5_rst");
    @(negedge CLK);
    stub_force_done = 1'b1;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check_val("t5_late_done", 64'(arith_state), 64'(ST_IDLE));
    check_val("t5_late_disp", disp, 64'd0);
    stub_force_done = 1'b0;
    stub_hang = 1'b0;
    @(negedge CLK);

    // digit rejection at the width limit and for non-decimal digits
    press_digit(12);
    check_val("t6_idle_rej", 64'({arith_state, dig_rej}), 64'({ST_IDLE, 1'b1}));
    enter_number(32'd4294967295, 1'b0);
    press_digit(1);
    check_val("t6_ovf_rej", 64'(dig_rej), 64'd1);
    check_val("t6_ovf_hold", disp, 64'd4294967295);
    @(negedge CLK);
    check_val("t6_rej_one_cycle", 64'(dig_rej), 64'd0);
    press_digit(12);
    check_val("t6_d12_rej", 64'(dig_rej), 64'd1);
    check_val("t6_d12_hold", 64'(arith_a), 64'd4294967295);
    press_clr();
    press_digit(5); press_op(OP_SUM); press_digit(3);
    press(1, 1, 0, 4'd0, 0, 4'd0);
    check_zero("t6_clr_eq");

    // random calculations, sometimes chained
    have_res = 1'b0;
    last_res = '0;
    for (int t = 0; t < 40; t++) begin
      op = ops[$urandom_range(0, 5)];
      stub_lat = $urandom_range(1, 6);
      if (have_res && $urandom_range(0, 2) == 0) begin
        a = last_res[31:0];
      end else begin
        if ($urandom_range(0, 4) == 0) press_clr();
        a = $urandom_range(0, 999999999);
        enter_number(a, 1'b1);
      end
      press_op(op);
      check_val("rnd_a", 64'(arith_a), 64'(a));
      b = '0;
      if (op != OP_SQRT) begin
        check_val("rnd_opsel", 64'(arith_state), 64'(ST_OPSEL));
        if (op == OP_POW)      b = $urandom_range(0, 3);
        else if (op == OP_DIV) b = $urandom_range(1, 99999);
        else                   b = $urandom_range(0, 99999);
        enter_number(b, 1'b1);
        press_eq();
        check_val("rnd_b", 64'(arith_b), 64'(b));
      end
      check_val("rnd_issue", 64'({busy, arith_opcode}), 64'({1'b1, op}));
      wait_busy(n);
      check_val("rnd_cycles", 64'(n), 64'(stub_lat));
      exp_res = ref_arith(op, a, b);
      check_val("rnd_result", disp, exp_res);
      check_val("rnd_show", 64'(arith_state), 64'(ST_SHOW));
      last_res = exp_res;
      have_res = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
